// File: rtl/stack_seq.sv
// Push/pull sequencer for a 6809-style register mask: walks the postbyte,
// drives the stack pointer strobes, the byte-wide memory port and the register file port.
module stack_seq (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic        pull,
    input  logic        use_s_in,
    input  logic [7:0]  postbyte,
    input  logic [15:0] reg_su,
    input  logic [15:0] reg_data,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        use_s,
    output logic [3:0]  path_left_addr,
    output logic        write_reg,
    output logic [3:0]  write_reg_addr,
    output logic [15:0] data_w,
    output logic        dec_su,
    output logic        inc_su,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_DEC,
        ST_WMEM,
        ST_RMEM,
        ST_INC,
        ST_WREG,
        ST_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic        pull_reg, pull_next;
    logic        use_s_reg, use_s_next;
    logic [7:0]  mask_reg, mask_next;
    logic [2:0]  bit_reg, bit_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [15:0] data_reg, data_next;

    logic [7:0]  push_pick;
    logic [7:0]  pull_pick;
    logic [7:0]  pick_vec;
    logic [2:0]  pick_idx;
    logic [3:0]  cur_code;
    logic        hi_byte;

    // One-hot pick per bit: push takes the highest set bit, pull the lowest.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pick
            assign push_pick[gi] = mask_reg[gi] & ~(|(mask_reg >> (gi + 1)));
            assign pull_pick[gi] = mask_reg[gi] & ~(|(mask_reg << (8 - gi)));
        end
    endgenerate

    always_comb begin
        pick_vec = pull_reg ? pull_pick : push_pick;
        pick_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pick_vec[i]) begin
                pick_idx = 3'(i);
            end
        end
    end

    // Postbyte bit to register code; bit 6 names the stack not in use.
    always_comb begin
        case (bit_reg)
            3'd7:    cur_code = 4'd5;
            3'd6:    cur_code = use_s_reg ? 4'd3 : 4'd4;
            3'd5:    cur_code = 4'd2;
            3'd4:    cur_code = 4'd1;
            3'd3:    cur_code = 4'd11;
            3'd2:    cur_code = 4'd9;
            3'd1:    cur_code = 4'd8;
            default: cur_code = 4'd10;
        endcase
    end

    // Pushes send the low byte first, so the high byte goes out when one byte remains.
    assign hi_byte = bit_reg[2] && (cnt_reg == 2'd1);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pull_reg  <= 1'b0;
            use_s_reg <= 1'b0;
            mask_reg  <= 8'h00;
            bit_reg   <= 3'd0;
            cnt_reg   <= 2'd0;
            data_reg  <= 16'h0000;
        end else begin
            state_reg <= state_next;
            pull_reg  <= pull_next;
            use_s_reg <= use_s_next;
            mask_reg  <= mask_next;
            bit_reg   <= bit_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pull_next  = pull_reg;
        use_s_next = use_s_reg;
        mask_next  = mask_reg;
        bit_next   = bit_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;

        busy           = 1'b0;
        done           = 1'b0;
        path_left_addr = 4'd0;
        write_reg      = 1'b0;
        write_reg_addr = 4'd0;
        data_w         = 16'h0000;
        dec_su         = 1'b0;
        inc_su         = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 16'h0000;
        mem_wdata      = 8'h00;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pull_next  = pull;
                    use_s_next = use_s_in;
                    mask_next  = postbyte;
                    state_next = ST_SEL;
                end
            end
            ST_SEL: begin
                busy = 1'b1;
                if (mask_reg == 8'h00) begin
                    state_next = ST_DONE;
                end else begin
                    bit_next   = pick_idx;
                    cnt_next   = pick_idx[2] ? 2'd2 : 2'd1;
                    data_next  = 16'h0000;
                    state_next = pull_reg ? ST_RMEM : ST_DEC;
                end
            end
            ST_DEC: begin
                busy           = 1'b1;
                dec_su         = 1'b1;
                path_left_addr = cur_code;
                state_next     = ST_WMEM;
            end
            ST_WMEM: begin
                busy           = 1'b1;
                path_left_addr = cur_code;
                mem_req        = 1'b1;
                mem_we         = 1'b1;
                mem_addr       = reg_su;
                mem_wdata      = hi_byte ? reg_data[15:8] : reg_data[7:0];
                if (mem_ack) begin
                    cnt_next = cnt_reg - 2'd1;
                    if (cnt_reg > 2'd1) begin
                        state_next = ST_DEC;
                    end else begin
                        mask_next[bit_reg] = 1'b0;
                        state_next         = ST_SEL;
                    end
                end
            end
            ST_RMEM: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = reg_su;
                if (mem_ack) begin
                    // Pulls arrive high byte first for 16-bit registers.
                    if (cnt_reg == 2'd2) begin
                        data_next[15:8] = mem_rdata;
                    end else begin
                        data_next[7:0] = mem_rdata;
                    end
                    cnt_next   = cnt_reg - 2'd1;
                    state_next = ST_INC;
                end
            end
            ST_INC: begin
                busy       = 1'b1;
                inc_su     = 1'b1;
                state_next = (cnt_reg != 2'd0) ? ST_RMEM : ST_WREG;
            end
            ST_WREG: begin
                busy               = 1'b1;
                write_reg          = 1'b1;
                write_reg_addr     = cur_code;
                data_w             = data_reg;
                mask_next[bit_reg] = 1'b0;
                state_next         = ST_SEL;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign use_s = use_s_reg;

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: register block and memory modelled in-bench, results compared
// against a transaction-level model of the push/pull rules.
module tb_stack_seq;

    logic        clk_in = 1'b0;
    logic        rst, start, pull, use_s_in;
    logic [7:0]  postbyte;
    logic [15:0] reg_su, reg_data;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        busy, done, use_s, write_reg, dec_su, inc_su, mem_req, mem_we;
    logic [3:0]  path_left_addr, write_reg_addr;
    logic [15:0] data_w, mem_addr;
    logic [7:0]  mem_wdata;

    stack_seq dut (
        .clk_in(clk_in), .rst(rst), .start(start), .pull(pull), .use_s_in(use_s_in),
        .postbyte(postbyte), .reg_su(reg_su), .reg_data(reg_data), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .busy(busy), .done(done), .use_s(use_s),
        .path_left_addr(path_left_addr), .write_reg(write_reg), .write_reg_addr(write_reg_addr),
        .data_w(data_w), .dec_su(dec_su), .inc_su(inc_su), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk_in = ~clk_in;

    logic [15:0] rf [0:15];
    logic [7:0]  mem [0:65535];
    int          wait_states;
    int          req_cnt;

    assign reg_su    = use_s ? rf[4] : rf[3];
    assign reg_data  = rf[path_left_addr];
    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && (req_cnt >= wait_states);

    int total, bad;
    int viol, n_dec, n_inc, n_req, req_len, last_req_len, done_cyc;
    bit done_seen, prev_dec, prev_inc, prev_wr, prev_pend, prev_mw;
    logic [15:0] prev_ma;
    logic [7:0]  prev_md;
    logic [3:0]  last_pla;
    logic [23:0] act_wr[$], exp_wr[$];
    logic [19:0] act_rw[$], exp_rw[$];
    int          exp_done, exp_dec, exp_inc;
    logic [15:0] exp_sp;

    typedef struct {
        bit          p;
        bit          us;
        logic [7:0]  pb;
        logic [15:0] sp;
        int          w;
        int          e_done;
        int          e_dec;
        int          e_inc;
        logic [15:0] e_sp;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return 64'({busy, done, use_s, path_left_addr, write_reg, write_reg_addr, data_w,
                    dec_su, inc_su, mem_req, mem_we, mem_addr, mem_wdata});
    endfunction

    function automatic logic [3:0] code_of(input int b, input bit us);
        case (b)
            7: return 4'd5;
            6: return us ? 4'd3 : 4'd4;
            5: return 4'd2;
            4: return 4'd1;
            3: return 4'd11;
            2: return 4'd9;
            1: return 4'd8;
            default: return 4'd10;
        endcase
    endfunction

    task automatic clear_mon();
        act_wr.delete(); act_rw.delete();
        viol = 0; n_dec = 0; n_inc = 0; n_req = 0; req_len = 0; last_req_len = 0;
        done_seen = 0; prev_dec = 0; prev_inc = 0; prev_wr = 0; prev_pend = 0;
        last_pla = 4'hF;
    endtask

    // Called at a falling edge: observe outputs, advance one clock, apply register/memory side effects.
    task automatic step();
        logic d, i, w, mr, mw, ack, us;
        logic [3:0]  wa;
        logic [15:0] wd, ma;
        logic [7:0]  md;
        d = dec_su; i = inc_su; w = write_reg; wa = write_reg_addr; wd = data_w;
        mr = mem_req; mw = mem_we; ma = mem_addr; md = mem_wdata; ack = mem_ack; us = use_s;
        if (int'(d) + int'(i) + int'(w) > 1) viol++;
        if ((d && prev_dec) || (i && prev_inc) || (w && prev_wr)) viol++;
        if ((d || i) && mr) viol++;
        if (mr && prev_pend && (ma !== prev_ma || md !== prev_md || mw !== prev_mw)) viol++;
        if (done) done_seen = 1;
        n_dec += int'(d);
        n_inc += int'(i);
        if (mr) begin
            n_req++;
            req_len++;
        end else begin
            req_len = 0;
        end
        if (mr && mw) last_pla = path_left_addr;
        if (mr && ack) begin
            last_req_len = req_len;
            req_len = 0;
        end
        if (mr && mw && ack) act_wr.push_back({ma, md});
        if (w) act_rw.push_back({wa, wd});
        prev_dec = d; prev_inc = i; prev_wr = w; prev_pend = mr && !ack;
        prev_ma = ma; prev_md = md; prev_mw = mw;
        @(posedge clk_in);
        #1;
        if (d) begin
            if (us) rf[4] = rf[4] - 16'd1; else rf[3] = rf[3] - 16'd1;
        end
        if (i) begin
            if (us) rf[4] = rf[4] + 16'd1; else rf[3] = rf[3] + 16'd1;
        end
        if (w) rf[wa] = wd;
        if (mr && mw && ack) mem[ma] = md;
        req_cnt = (mr && !ack) ? req_cnt + 1 : 0;
        @(negedge clk_in);
    endtask

    // Transaction-level expectation built straight from the push/pull rules.
    task automatic model(input bit p, input bit us, input logic [7:0] pb, input int w);
        logic [15:0] sp, v;
        logic [3:0]  c;
        int          n, cyc, b;
        exp_wr.delete(); exp_rw.delete();
        exp_dec = 0; exp_inc = 0; cyc = 2;
        sp = us ? rf[4] : rf[3];
        for (int k = 0; k < 8; k++) begin
            b = p ? k : 7 - k;
            if (pb[b]) begin
                c = code_of(b, us);
                n = (b >= 4) ? 2 : 1;
                cyc += 1 + n * (2 + w) + (p ? 1 : 0);
                if (!p) begin
                    v = rf[c];
                    sp = sp - 16'd1;
                    exp_wr.push_back({sp, v[7:0]});
                    if (n == 2) begin
                        sp = sp - 16'd1;
                        exp_wr.push_back({sp, v[15:8]});
                    end
                    exp_dec += n;
                end else begin
                    if (n == 2) begin
                        v[15:8] = mem[sp];
                        sp = sp + 16'd1;
                        v[7:0] = mem[sp];
                        sp = sp + 16'd1;
                    end else begin
                        v = {8'h00, mem[sp]};
                        sp = sp + 16'd1;
                    end
                    exp_rw.push_back({c, v});
                    exp_inc += n;
                end
            end
        end
        exp_sp = sp;
        exp_done = cyc;
    endtask

    task automatic run_seq(input bit p, input bit us, input logic [7:0] pb, input int w, input bit poke);
        clear_mon();
        wait_states = w;
        done_cyc = -1;
        pull = p; use_s_in = us; postbyte = pb; start = 1'b1;
        step();
        start = 1'b0; pull = ~p; use_s_in = ~us; postbyte = ~pb;
        for (int k = 1; k < 400; k++) begin
            start = poke && (k == 3);
            if (done) begin
                if (busy) viol++;
                done_cyc = k;
                break;
            end
            if (!busy) viol++;
            step();
        end
        start = 1'b0;
        step();
        if (done || busy) viol++;
        $display("seq %s us=%0d pb=%02h wait=%0d done_at=%0d", p ? "pul" : "psh", us, pb, w, done_cyc);
    endtask

    task automatic check_seq(input string name, input bit us);
        int m;
        chk({name, "_done"}, 64'(done_cyc), 64'(exp_done));
        chk({name, "_dec"}, 64'(n_dec), 64'(exp_dec));
        chk({name, "_inc"}, 64'(n_inc), 64'(exp_inc));
        chk({name, "_sp"}, 64'(us ? rf[4] : rf[3]), 64'(exp_sp));
        chk({name, "_nwr"}, 64'(act_wr.size()), 64'(exp_wr.size()));
        chk({name, "_nrw"}, 64'(act_rw.size()), 64'(exp_rw.size()));
        m = 0;
        for (int j = 0; j < act_wr.size() && j < exp_wr.size(); j++) if (act_wr[j] !== exp_wr[j]) m++;
        for (int j = 0; j < act_rw.size() && j < exp_rw.size(); j++) if (act_rw[j] !== exp_rw[j]) m++;
        chk({name, "_data"}, 64'(m), 64'(0));
        chk({name, "_proto"}, 64'(viol), 64'(0));
    endtask

    initial begin
        logic [23:0] want39 [4];
        total = 0; bad = 0;
        rst = 1'b0; start = 1'b0; pull = 1'b0; use_s_in = 1'b0; postbyte = 8'h00;
        wait_states = 0; req_cnt = 0;
        for (int j = 0; j < 16; j++) rf[j] = 16'h0000;
        for (int j = 0; j < 65536; j++) mem[j] = 8'($urandom);

        //           p  us  pb     sp        w  done dec inc  e_sp
        vecs[0] = '{0, 1, 8'h16, 16'h0F00, 0, 13,  4,  0, 16'h0EFC};
        vecs[1] = '{1, 0, 8'h81, 16'h0E00, 0, 12,  0,  3, 16'h0E03};
        vecs[2] = '{0, 1, 8'h00, 16'h1000, 0,  2,  0,  0, 16'h1000};
        vecs[3] = '{0, 1, 8'h40, 16'h2000, 0,  7,  2,  0, 16'h1FFE};
        vecs[4] = '{1, 1, 8'hFF, 16'h3000, 0, 42,  0, 12, 16'h300C};
        vecs[5] = '{0, 0, 8'hFF, 16'h4000, 0, 34, 12,  0, 16'h3FF4};
        vecs[6] = '{0, 1, 8'h80, 16'h0001, 0,  7,  2,  0, 16'hFFFF};
        vecs[7] = '{1, 0, 8'h01, 16'hFFFF, 0,  6,  0,  1, 16'h0000};
        vecs[8] = '{0, 1, 8'h16, 16'h0F00, 1, 17,  4,  0, 16'h0EFC};

        // Asynchronous reset takes effect before any clock edge
        #1 rst = 1'b1;
        #2 chk("reset_outputs", all_out(), 64'(0));
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        step();
        chk("idle_outputs", all_out(), 64'(0));

        for (int t = 0; t < 9; t++) begin
            string nm;
            nm = $sformatf("vec%0d", t);
            if (vecs[t].us) rf[4] = vecs[t].sp; else rf[3] = vecs[t].sp;
            rf[1] = 16'h5678; rf[2] = 16'h9ABC; rf[5] = 16'hC0DE;
            rf[8] = 16'h0012; rf[9] = 16'h0034; rf[10] = 16'h00D0; rf[11] = 16'h0077;
            if (vecs[t].us) rf[3] = 16'hA55A; else rf[4] = 16'h5AA5;
            model(vecs[t].p, vecs[t].us, vecs[t].pb, vecs[t].w);
            run_seq(vecs[t].p, vecs[t].us, vecs[t].pb, vecs[t].w, 1'b0);
            chk({nm, "_tdone"}, 64'(done_cyc), 64'(vecs[t].e_done));
            chk({nm, "_tdec"}, 64'(n_dec), 64'(vecs[t].e_dec));
            chk({nm, "_tinc"}, 64'(n_inc), 64'(vecs[t].e_inc));
            chk({nm, "_tsp"}, 64'(vecs[t].us ? rf[4] : rf[3]), 64'(vecs[t].e_sp));
            check_seq(nm, vecs[t].us);
        end

        // PSHS A,B,X with exact write order
        want39 = '{24'h0EFF78, 24'h0EFE56, 24'h0EFD34, 24'h0EFC12};
        rf[4] = 16'h0F00; rf[8] = 16'h0012; rf[9] = 16'h0034; rf[1] = 16'h5678;
        run_seq(1'b0, 1'b1, 8'h16, 0, 1'b0);
        chk("pshs_nwr", 64'(act_wr.size()), 64'(4));
        for (int j = 0; j < 4 && j < act_wr.size(); j++) chk($sformatf("pshs_wr%0d", j), 64'(act_wr[j]), 64'(want39[j]));
        chk("pshs_done", 64'(done_cyc), 64'(13));
        chk("pshs_s", 64'(rf[4]), 64'(16'h0EFC));

        // PULU CC,PC
        rf[3] = 16'h0E00; mem[16'h0E00] = 8'hD0; mem[16'h0E01] = 8'h12; mem[16'h0E02] = 8'h34;
        run_seq(1'b1, 1'b0, 8'h81, 0, 1'b0);
        chk("pulu_nrw", 64'(act_rw.size()), 64'(2));
        if (act_rw.size() >= 2) begin
            chk("pulu_rw0", 64'(act_rw[0]), 64'({4'd10, 16'h00D0}));
            chk("pulu_rw1", 64'(act_rw[1]), 64'({4'd5, 16'h1234}));
        end
        chk("pulu_inc", 64'(n_inc), 64'(3));
        chk("pulu_u", 64'(rf[3]), 64'(16'h0E03));

        // Empty mask touches neither memory nor stack pointer
        run_seq(1'b0, 1'b1, 8'h00, 0, 1'b0);
        chk("empty_done", 64'(done_cyc), 64'(2));
        chk("empty_req", 64'(n_req), 64'(0));
        chk("empty_strobes", 64'(n_dec + n_inc), 64'(0));

        // Bit 6 names the other stack
        rf[4] = 16'h2000; rf[3] = 16'h1111;
        run_seq(1'b0, 1'b1, 8'h40, 0, 1'b0);
        chk("bit6_s_code", 64'(last_pla), 64'(3));
        rf[3] = 16'h3000; rf[4] = 16'h2222;
        run_seq(1'b0, 1'b0, 8'h40, 0, 1'b0);
        chk("bit6_u_code", 64'(last_pla), 64'(4));

        // Three wait states plus a stray start while busy
        rf[4] = 16'h0F00; rf[8] = 16'h00AB; rf[9] = 16'h00CD; rf[1] = 16'h1357;
        model(1'b0, 1'b1, 8'h16, 3);
        run_seq(1'b0, 1'b1, 8'h16, 3, 1'b1);
        check_seq("wait3", 1'b1);
        chk("wait3_reqlen", 64'(last_req_len), 64'(4));

        // Reset in the middle of a memory write
        rf[4] = 16'h0800; rf[1] = 16'hBEEF;
        clear_mon();
        wait_states = 10;
        pull = 1'b0; use_s_in = 1'b1; postbyte = 8'h10; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10 && !mem_req; k++) step();
        chk("rst_in_wmem", 64'(mem_req), 64'(1));
        #2 rst = 1'b1;
        req_cnt = 0;
        #1 chk("rst_mid_outputs", all_out(), 64'(0));
        chk("rst_sp_kept", 64'(rf[4]), 64'(16'h07FF));
        @(negedge clk_in);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_no_done", 64'(done_seen), 64'(0));
        chk("rst_idle", all_out(), 64'(0));
        model(1'b0, 1'b1, 8'h10, 0);
        run_seq(1'b0, 1'b1, 8'h10, 0, 1'b0);
        check_seq("after_rst", 1'b1);

        // Randomized sequences
        for (int it = 0; it < 30; it++) begin
            bit p, us;
            logic [7:0] pb;
            int w;
            p = 1'($urandom_range(0, 1));
            us = 1'($urandom_range(0, 1));
            pb = 8'($urandom);
            w = $urandom_range(0, 2);
            for (int c = 1; c <= 5; c++) rf[c] = 16'($urandom);
            for (int c = 8; c <= 11; c++) rf[c] = {8'h00, 8'($urandom)};
            model(p, us, pb, w);
            run_seq(p, us, pb, w, 1'($urandom_range(0, 1)));
            check_seq($sformatf("rnd%0d", it), us);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
